// File: rtl/rf_wb_pkg.sv
// Shared definitions for the register-file writeback controller.
//   XLEN / AW / NREG : data width, register address width, register count
//   wb_entry_t       : one completed result {rd, data}
//   ERR_WAW/ERR_SPUR : bit positions within the sticky err vector
package rf_wb_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 1 << AW;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    localparam int unsigned ERR_WAW  = 0;
    localparam int unsigned ERR_SPUR = 1;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of writeback entries used to hold load results.
//   clk, reset            : clock, synchronous active-high reset (flushes)
//   push, push_data       : enqueue; ignored while full
//   pop, pop_data         : dequeue head; pop_data shows the head while !empty
//   count, full, empty    : occupancy
// DEPTH must be a power of 2 so the pointers wrap naturally.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  wb_entry_t                    push_data,
    input  logic                         pop,
    output wb_entry_t                    pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rf_writeback.sv
// Register-file writer: arbitrates ALU and load results onto the single
// write port and tracks pending destinations for decode hazard stalls.
//   clk, reset                         : clock, synchronous active-high reset
//   iss_valid, iss_rd                  : decode issues a writer of iss_rd
//   chk_rs1/rs2/rd, hazard             : combinational busy lookup for decode
//   alu_valid, alu_rd, alu_data        : ALU result, always accepted
//   mem_valid, mem_ready, mem_rd/data  : load result handshake (queued)
//   mq_full                            : load queue full; decode bubbles ALU
//   rg_wrt_en/addr/data                : registered register-file write port
//   err                                : sticky {spurious write, WAW issue}
module rf_writeback
    import rf_wb_pkg::*;
#(
    parameter int unsigned XLEN     = rf_wb_pkg::XLEN,
    parameter int unsigned AW       = rf_wb_pkg::AW,
    parameter int unsigned MQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    input  logic [AW-1:0]   chk_rd,
    output logic            hazard,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mq_full,
    output logic            rg_wrt_en,
    output logic [AW-1:0]   rg_wrt_addr,
    output logic [XLEN-1:0] rg_wrt_data,
    output logic [1:0]      err
);

    localparam int unsigned NR = 1 << AW;
    localparam int unsigned CW = $clog2(MQ_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(MQ_DEPTH);

    logic [NR-1:0] busy;
    logic [NR-1:0] busy_nxt;
    wb_entry_t     mem_in;
    wb_entry_t     mq_head;
    wb_entry_t     sel;
    logic          sel_valid;
    logic          mq_push;
    logic          mq_pop;
    logic          mq_empty;
    logic          mq_full_i;
    logic [CW-1:0] mq_count;

    assign mem_in    = '{rd: mem_rd, data: mem_data};
    assign mem_ready = !reset && (mq_count < DEPTH_C);
    assign mq_full   = mq_full_i;
    assign mq_push   = mem_valid && mem_ready;
    // ALU has absolute priority; the queue only drains in ALU-free cycles.
    assign mq_pop    = !alu_valid && !mq_empty;
    assign sel_valid = alu_valid || !mq_empty;
    assign hazard    = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];

    rf_wb_fifo #(
        .DEPTH (MQ_DEPTH)
    ) u_mq (
        .clk       (clk),
        .reset     (reset),
        .push      (mq_push),
        .push_data (mem_in),
        .pop       (mq_pop),
        .pop_data  (mq_head),
        .count     (mq_count),
        .full      (mq_full_i),
        .empty     (mq_empty)
    );

    always_comb begin
        sel = mq_head;
        if (alu_valid) begin
            sel = '{rd: alu_rd, data: alu_data};
        end
    end

    // Clear for the write committing this edge first, then set for a new
    // issue, so an issue to the same register stays pending.
    always_comb begin
        busy_nxt = busy;
        if (rg_wrt_en) busy_nxt[rg_wrt_addr] = 1'b0;
        if (iss_valid && iss_rd != '0) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= '0;
            err         <= '0;
            rg_wrt_en   <= 1'b0;
            rg_wrt_addr <= '0;
            rg_wrt_data <= '0;
        end else begin
            busy <= busy_nxt;
            if (iss_valid && iss_rd != '0 && busy[iss_rd]) begin
                err[ERR_WAW] <= 1'b1;
            end
            if (sel_valid && sel.rd != '0 && !busy[sel.rd]) begin
                err[ERR_SPUR] <= 1'b1;
            end
            // Results to x0 are consumed without producing a write.
            rg_wrt_en <= sel_valid && (sel.rd != '0);
            if (sel_valid) begin
                rg_wrt_addr <= sel.rd;
                rg_wrt_data <= sel.data;
            end
        end
    end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Writer-side controller for the 32x32 register file. Collects completed results from the single-cycle ALU and the multi-cycle load unit, arbitrates them onto the register file's single write port (`rg_wrt_en/addr/data`), and keeps a pending-destination scoreboard so decode can stall on read-after-write (RAW) and write-after-write (WAW) hazards. It sits between the execute/memory stages and the register file write port.

## Interface
- `XLEN`, default 32: data width.
- `AW`, default 5: register address width (32 registers).
- `MQ_DEPTH`, default 2: load-result queue depth; must be a power of 2.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `iss_valid` in 1: decode issues an instruction that writes `iss_rd`.
- `iss_rd` in AW: destination register of the issued instruction.
- `chk_rs1`, `chk_rs2`, `chk_rd` in AW each: registers decode is about to use.
- `hazard` out 1: combinational; `busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]`.
- `alu_valid` in 1: ALU result present this cycle. No backpressure; always accepted.
- `alu_rd` in AW, `alu_data` in XLEN: ALU destination register and value.
- `mem_valid` in 1, `mem_ready` out 1: load result handshake.
- `mem_rd` in AW, `mem_data` in XLEN: load destination register and value.
- `mq_full` out 1: load queue full. Decode must insert a bubble (no ALU result next cycle) while this is high.
- `rg_wrt_en` out 1, `rg_wrt_addr` out AW, `rg_wrt_data` out XLEN: registered write port to the register file.
- `err` out 2: sticky error flags. Bit 0 = WAW issue (issue to a register already busy). Bit 1 = spurious write (result whose rd is not busy).

## Operation
- Scoreboard `busy[31:0]`. Bit 0 is hard-wired 0.
  - Set at the edge where `iss_valid && iss_rd != 0`.
  - Cleared at the edge where `rg_wrt_en == 1` for `rg_wrt_addr`, i.e. the same edge the register file commits the value.
  - If set and clear hit the same register on the same edge, set wins (the new instruction stays pending).
- Load queue: FIFO of {rd, data}, MQ_DEPTH entries.
  - Push on `mem_valid && mem_ready`.
  - `mem_ready = !reset && count < MQ_DEPTH`.
  - `mq_full = (count == MQ_DEPTH)`.
- Arbitration, evaluated each cycle, fixed priority:
  1. If `alu_valid`: select the ALU result.
  2. Else if queue not empty: pop the head and select it.
  3. Else: nothing selected.
  - Load results always pass through the queue; there is no direct mem-to-port path.
- Output register, updated at the edge after selection:
  - `rg_wrt_en` = selected && rd != 0.
  - addr/data = the selected entry.
  - A result to x0 is consumed (popped / accepted) but produces no write.
- Push and pop on the same edge: count unchanged, FIFO order preserved.
- Error flags:
  - `err[0]` sets on `iss_valid` with `iss_rd != 0 && busy[iss_rd]`.
  - `err[1]` sets when a selected result with rd != 0 has its busy bit clear.
  - Both flags are cleared only by reset.

## Timing
- Reset state:
  - `rg_wrt_en` = 0, `rg_wrt_addr` = 0, `rg_wrt_data` = 0.
  - `busy` = 0, queue empty, `err` = 0.
  - `mem_ready` = 0 while reset is high; 1 in the first cycle after reset.
  - `hazard` = 0, `mq_full` = 0.
- ALU latency: `alu_valid` in cycle N → `rg_wrt_en` high in N+1 → register file and busy bit updated at the end of N+1. Reads in N+2 see the new value and `hazard` drops.
- Load latency, empty queue, no ALU competition: handshake in N → `rg_wrt_en` in N+2.
- Sustained throughput: one write per cycle.
- While the queue is full with `alu_valid` high, the queue holds. The decode bubble rule guarantees a drain slot.
- Reset mid-operation:
  - The output register is cleared, so an in-flight write is dropped.
  - The queue is flushed and the scoreboard cleared.
  - Upstream is responsible for squashing its own state.

## Structure
- Shared package `rf_wb_pkg`:
  - `XLEN`, `AW`, `NREG = 1 << AW`.
  - `typedef struct packed {logic [AW-1:0] rd; logic [XLEN-1:0] data;} wb_entry_t`.
  - Error bit index constants `ERR_WAW = 0`, `ERR_SPUR = 1`.
- One sub-module, `rf_wb_fifo`:
  - Parameterized synchronous FIFO of `wb_entry_t` with push, pop, count, full and empty.
  - Depth MQ_DEPTH; pointers wrap modulo depth.
- Top level holds the arbiter, output register, scoreboard and error logic.

## Test plan
- ALU write and hazard: `iss_valid`, `iss_rd` = 5 → `hazard` = 1 for `chk_rs1` = 5. Then `alu_valid`, rd = 5, data = 0xDEADBEEF → next cycle `rg_wrt_en` = 1, addr = 5, data = 0xDEADBEEF; `hazard` = 0 one cycle later.
- x0 suppression: issue rd = 0, then `alu_valid` rd = 0 → `busy` stays 0, `rg_wrt_en` never asserts, `err` = 0.
- Priority and queueing:
  - Load rd = 7 / 0x11 accepted while the ALU writes rd = 3 for 3 cycles → load writes the cycle after the ALU stream ends.
  - Second load rd = 8 / 0x22 fills the queue → `mq_full` = 1, `mem_ready` = 0.
  - Writes complete in order 7 then 8.
- Same-edge set/clear: issue rd = 9 on the edge where the prior rd = 9 write commits → `busy[9]` remains 1, `err[0]` = 1 (WAW).
- Spurious write: `alu_valid` rd = 12 with `busy[12]` = 0 → write still occurs, `err[1]` = 1 and stays set until reset.
- Reset mid-operation: reset asserted with 2 queue entries, busy = 0x0000_0480 and `rg_wrt_en` = 1 → next cycle all outputs 0, queue empty; `mem_ready` = 1 the cycle after reset deasserts.
